// File: rtl/mem_arbiter_params.sv
// Shared types for the memory request arbiter.
//   owner_e        : which requester owns a downstream request (instruction or data)
//   queue_entry_t  : one outstanding-response record {owner, discard}
//   DEFAULT_QUEUE_DEPTH : default number of accepted-but-unanswered requests
package mem_arbiter_params;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   discard;
  } queue_entry_t;

  localparam int unsigned DEFAULT_QUEUE_DEPTH = 2;

  // Build a queue entry from its fields.
  function automatic queue_entry_t make_entry(input owner_e owner, input logic discard);
    queue_entry_t e;
    e.owner   = owner;
    e.discard = discard;
    return e;
  endfunction

endpackage

// File: rtl/response_queue.sv
// Circular FIFO of response owners for requests already accepted downstream.
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   push_i, push_entry_i  : append one entry (ignored when full)
//   pop_i                 : drop the head entry (ignored when empty)
//   mark_inst_discard_i   : set discard on every stored instruction entry
//   full_o, empty_o       : occupancy flags (full means count == DEPTH)
//   head_o                : oldest entry
module response_queue
  import mem_arbiter_params::*;
#(
  parameter int unsigned DEPTH = DEFAULT_QUEUE_DEPTH
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push_i,
  input  queue_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         mark_inst_discard_i,
  output logic         full_o,
  output logic         empty_o,
  output queue_entry_t head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  queue_entry_t     entries_q [DEPTH];
  queue_entry_t     entries_d [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointers wrap modulo DEPTH so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == CNT_W'(0));
  assign head_o  = entries_q[rd_ptr_q];

  // Next-state for pointers, count and storage.
  always_comb begin
    push_ok_s = push_i & ~full_o;
    pop_ok_s  = pop_i & ~empty_o;
    wr_ptr_d  = push_ok_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    for (int i = 0; i < int'(DEPTH); i++) begin
      entries_d[i] = entries_q[i];
      // A freshly pushed entry overrides any marking of the stale slot.
      if (push_ok_s && (wr_ptr_q == PTR_W'(i))) begin
        entries_d[i] = push_entry_i;
      end else begin
        entries_d[i].discard = entries_q[i].discard |
                               (mark_inst_discard_i & (entries_q[i].owner == OWNER_INST));
      end
    end
  end

  // Queue state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= make_entry(OWNER_INST, 1'b0);
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Two-requester (instruction / data) arbiter in front of one memory port.
// Data wins over instruction in an unlocked cycle; a request that is shown
// downstream but not accepted locks the grant until acceptance. Accepted
// requests are tracked in response_queue so responses are routed in order.
// Ports:
//   clock, reset_n            : clock, asynchronous active-low reset
//   inst_* / data_*           : requester request channels and response outputs
//   mem_*                     : downstream request channel and response inputs
//   inst_cancel               : drop responses of all accepted instruction requests
//   protocol_error            : sticky; mem_data_ready seen with empty queue
module mem_request_arbiter
  import mem_arbiter_params::*;
#(
  parameter int unsigned QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
  input  logic        clock,
  input  logic        reset_n,
  // instruction requester
  input  logic        inst_request,
  input  logic        inst_write,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_address,
  input  logic [31:0] inst_write_data,
  input  logic [3:0]  inst_write_strobe,
  output logic        inst_address_ready,
  output logic        inst_data_ready,
  output logic [31:0] inst_read_data,
  // data requester
  input  logic        data_request,
  input  logic        data_write,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_address,
  input  logic [31:0] data_write_data,
  input  logic [3:0]  data_write_strobe,
  output logic        data_address_ready,
  output logic        data_data_ready,
  output logic [31:0] data_read_data,
  // downstream
  output logic        mem_request,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_strobe,
  input  logic [31:0] mem_read_data,
  input  logic        mem_address_ready,
  input  logic        mem_data_ready,
  // control / status
  input  logic        inst_cancel,
  output logic        protocol_error
);

  owner_e       grant_owner_s;
  logic         granted_req_s;
  logic         mem_request_s;
  logic         accept_s;
  logic         pop_s;
  logic         queue_full_s;
  logic         queue_empty_s;
  logic         head_discard_s;
  queue_entry_t push_entry_s;
  queue_entry_t head_s;

  logic         lock_q, lock_d;
  owner_e       lock_owner_q, lock_owner_d;
  logic         cancel_pending_q, cancel_pending_d;
  logic         protocol_error_q, protocol_error_d;

  // Grant selection: a locked owner keeps the port, otherwise data has priority.
  always_comb begin
    grant_owner_s = OWNER_INST;
    if (lock_q) begin
      grant_owner_s = lock_owner_q;
    end else if (data_request) begin
      grant_owner_s = OWNER_DATA;
    end else begin
      grant_owner_s = OWNER_INST;
    end
  end

  // Forward the granted requester's fields to the downstream port.
  always_comb begin
    granted_req_s    = 1'b0;
    mem_write        = 1'b0;
    mem_size         = 2'b00;
    mem_address      = 32'h0000_0000;
    mem_write_data   = 32'h0000_0000;
    mem_write_strobe = 4'b0000;
    case (grant_owner_s)
      OWNER_DATA: begin
        granted_req_s    = data_request;
        mem_write        = data_write;
        mem_size         = data_size;
        mem_address      = data_address;
        mem_write_data   = data_write_data;
        mem_write_strobe = data_write_strobe;
      end
      OWNER_INST: begin
        granted_req_s    = inst_request;
        mem_write        = inst_write;
        mem_size         = inst_size;
        mem_address      = inst_address;
        mem_write_data   = inst_write_data;
        mem_write_strobe = inst_write_strobe;
      end
      default: begin
        granted_req_s    = 1'b0;
        mem_write        = 1'b0;
        mem_size         = 2'b00;
        mem_address      = 32'h0000_0000;
        mem_write_data   = 32'h0000_0000;
        mem_write_strobe = 4'b0000;
      end
    endcase
  end

  // Full is judged on the registered count: a same-cycle pop does not free a slot.
  assign mem_request_s = reset_n & granted_req_s & ~queue_full_s;
  assign accept_s      = mem_request_s & mem_address_ready;
  assign mem_request   = mem_request_s;

  assign inst_address_ready = accept_s & (grant_owner_s == OWNER_INST);
  assign data_address_ready = accept_s & (grant_owner_s == OWNER_DATA);

  // An instruction entry is born discarded if a cancel hit it this cycle or
  // while it was waiting, locked, for acceptance.
  assign push_entry_s = make_entry(grant_owner_s,
                                   (grant_owner_s == OWNER_INST) &
                                   (inst_cancel | cancel_pending_q));

  // Response routing; a cancel in the same cycle also suppresses the head.
  assign pop_s          = reset_n & mem_data_ready & ~queue_empty_s;
  assign head_discard_s = head_s.discard | (inst_cancel & (head_s.owner == OWNER_INST));
  assign inst_data_ready = pop_s & (head_s.owner == OWNER_INST) & ~head_discard_s;
  assign data_data_ready = pop_s & (head_s.owner == OWNER_DATA) & ~head_discard_s;
  assign inst_read_data  = mem_read_data;
  assign data_read_data  = mem_read_data;
  assign protocol_error  = protocol_error_q;

  // Lock, pending-cancel and error next-state.
  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (lock_q) begin
      lock_d = ~accept_s;
    end else if (mem_request_s && !mem_address_ready) begin
      lock_d       = 1'b1;
      lock_owner_d = grant_owner_s;
    end else begin
      lock_d = 1'b0;
    end
    // Pending cancel lives exactly as long as an instruction lock does.
    cancel_pending_d = lock_d & (lock_owner_d == OWNER_INST) &
                       (cancel_pending_q | inst_cancel);
    protocol_error_d = protocol_error_q | (mem_data_ready & queue_empty_s);
  end

  // Control registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_q           <= 1'b0;
      lock_owner_q     <= OWNER_INST;
      cancel_pending_q <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      lock_q           <= lock_d;
      lock_owner_q     <= lock_owner_d;
      cancel_pending_q <= cancel_pending_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  response_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clock               (clock),
    .reset_n             (reset_n),
    .push_i              (accept_s),
    .push_entry_i        (push_entry_s),
    .pop_i               (pop_s),
    .mark_inst_discard_i (inst_cancel),
    .full_o              (queue_full_s),
    .empty_o             (queue_empty_s),
    .head_o              (head_s)
  );

endmodule

// File: tb/tb_mem_request_arbiter.sv
module tb_mem_request_arbiter;

  localparam int QD = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        inst_request, inst_write, inst_address_ready, inst_data_ready;
  logic [1:0]  inst_size;
  logic [31:0] inst_address, inst_write_data, inst_read_data;
  logic [3:0]  inst_write_strobe;
  logic        data_request, data_write, data_address_ready, data_data_ready;
  logic [1:0]  data_size;
  logic [31:0] data_address, data_write_data, data_read_data;
  logic [3:0]  data_write_strobe;
  logic        mem_request, mem_write, mem_address_ready, mem_data_ready;
  logic [1:0]  mem_size;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [3:0]  mem_write_strobe;
  logic        inst_cancel, protocol_error;

  mem_request_arbiter #(.QUEUE_DEPTH(QD)) dut (
    .clock(clock), .reset_n(reset_n),
    .inst_request(inst_request), .inst_write(inst_write), .inst_size(inst_size),
    .inst_address(inst_address), .inst_write_data(inst_write_data),
    .inst_write_strobe(inst_write_strobe), .inst_address_ready(inst_address_ready),
    .inst_data_ready(inst_data_ready), .inst_read_data(inst_read_data),
    .data_request(data_request), .data_write(data_write), .data_size(data_size),
    .data_address(data_address), .data_write_data(data_write_data),
    .data_write_strobe(data_write_strobe), .data_address_ready(data_address_ready),
    .data_data_ready(data_data_ready), .data_read_data(data_read_data),
    .mem_request(mem_request), .mem_write(mem_write), .mem_size(mem_size),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_strobe(mem_write_strobe), .mem_read_data(mem_read_data),
    .mem_address_ready(mem_address_ready), .mem_data_ready(mem_data_ready),
    .inst_cancel(inst_cancel), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: ordered list of outstanding responses plus held grant.
  typedef struct {
    bit is_data;
    bit discard;
  } ment_t;
  ment_t mq[$];
  bit m_locked, m_lock_data, m_pend, m_perr;

  task automatic model_reset();
    mq.delete();
    m_locked = 1'b0;
    m_lock_data = 1'b0;
    m_pend = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic idle();
    inst_request = 1'b0; data_request = 1'b0;
    mem_address_ready = 1'b0; mem_data_ready = 1'b0; inst_cancel = 1'b0;
  endtask

  // Check one cycle's outputs against the model, advance the model, move to next cycle.
  task automatic step();
    bit is_data, req, mreq, acc, pop, disc, e_idr, e_ddr;
    logic [70:0] e_fwd;
    ment_t h, ne;
    #1;
    is_data = m_locked ? m_lock_data : (data_request == 1'b1);
    req  = is_data ? data_request : inst_request;
    mreq = req && (mq.size() < QD);
    acc  = mreq && mem_address_ready;
    pop  = mem_data_ready && (mq.size() > 0);
    e_idr = 1'b0; e_ddr = 1'b0;
    if (pop) begin
      h = mq[0];
      disc  = h.discard || (inst_cancel && !h.is_data);
      e_idr = !h.is_data && !disc;
      e_ddr = h.is_data && !disc;
    end
    e_fwd = is_data ? {data_write, data_size, data_address, data_write_data, data_write_strobe}
                    : {inst_write, inst_size, inst_address, inst_write_data, inst_write_strobe};
    check_eq("mem_request", mem_request, mreq);
    check_eq("mem_fields", {mem_write, mem_size, mem_address, mem_write_data, mem_write_strobe}, e_fwd);
    check_eq("inst_addr_rdy", inst_address_ready, acc && !is_data);
    check_eq("data_addr_rdy", data_address_ready, acc && is_data);
    check_eq("inst_data_rdy", inst_data_ready, e_idr);
    check_eq("data_data_rdy", data_data_ready, e_ddr);
    check_eq("read_data", {inst_read_data, data_read_data}, {mem_read_data, mem_read_data});
    check_eq("protocol_error", protocol_error, m_perr);
    if (mem_data_ready && mq.size() == 0) m_perr = 1'b1;
    if (inst_cancel) begin
      foreach (mq[i]) if (!mq[i].is_data) mq[i].discard = 1'b1;
    end
    if (pop) void'(mq.pop_front());
    if (acc) begin
      ne.is_data = is_data;
      ne.discard = !is_data && (inst_cancel || m_pend);
      mq.push_back(ne);
    end
    if (acc) m_locked = 1'b0;
    else if (mreq) begin
      m_locked = 1'b1;
      m_lock_data = is_data;
    end
    m_pend = m_locked && !m_lock_data && (m_pend || inst_cancel);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    inst_write = 1'b0; inst_size = 2'b10; inst_write_data = 32'h0; inst_write_strobe = 4'h0;
    data_write = 1'b1; data_size = 2'b10; data_write_data = 32'h1234_5678; data_write_strobe = 4'hf;
    inst_address = 32'hbfc0_0000; data_address = 32'h8000_1000; mem_read_data = 32'h0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_mem_request", mem_request, 1'b0);
    check_eq("rst_perr", protocol_error, 1'b0);
    check_eq("rst_count", dut.u_queue.count_q, 0);
    reset_n = 1'b1;

    // Simultaneous requests: data first, then instruction, responses in order.
    inst_request = 1'b1; data_request = 1'b1; mem_address_ready = 1'b1;
    #1;
    check_eq("both_first_addr", mem_address, 32'h8000_1000);
    check_eq("both_first_dar", data_address_ready, 1'b1);
    step();
    data_request = 1'b0;
    #1;
    check_eq("both_second_addr", mem_address, 32'hbfc0_0000);
    check_eq("both_second_iar", inst_address_ready, 1'b1);
    step();
    idle(); mem_data_ready = 1'b1; mem_read_data = 32'hdead_beef;
    #1;
    check_eq("resp1_ddr", {data_data_ready, inst_data_ready}, 2'b10);
    check_eq("resp1_rdata", data_read_data, 32'hdead_beef);
    step();
    mem_read_data = 32'hcafe_f00d;
    #1;
    check_eq("resp2_idr", {data_data_ready, inst_data_ready}, 2'b01);
    step();

    // Locked instruction grant survives a later data request.
    idle(); inst_request = 1'b1;
    step();
    data_request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("lock_addr", mem_address, 32'hbfc0_0000);
      check_eq("lock_dar", data_address_ready, 1'b0);
      step();
    end
    mem_address_ready = 1'b1;
    #1;
    check_eq("lock_release_iar", inst_address_ready, 1'b1);
    step();
    inst_request = 1'b0;
    step();
    idle(); mem_data_ready = 1'b1;
    repeat (2) step();
    idle();

    // Queue full: third accept blocked until after a pop.
    inst_request = 1'b1; mem_address_ready = 1'b1;
    repeat (2) step();
    #1;
    check_eq("full_blocked", mem_request, 1'b0);
    step();
    mem_data_ready = 1'b1;
    #1;
    check_eq("full_no_bypass", mem_request, 1'b0);
    step();
    mem_data_ready = 1'b0;
    #1;
    check_eq("full_after_pop", mem_request, 1'b1);
    step();
    idle(); mem_data_ready = 1'b1;
    repeat (2) step();
    idle();

    // Cancel of two outstanding instruction requests.
    inst_request = 1'b1; mem_address_ready = 1'b1;
    repeat (2) step();
    idle(); inst_cancel = 1'b1;
    step();
    idle(); mem_data_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("cancel_idr", inst_data_ready, 1'b0);
      step();
    end
    idle();
    check_eq("cancel_count", dut.u_queue.count_q, 0);

    // Response with empty queue sets sticky error.
    mem_data_ready = 1'b1;
    step();
    idle();
    step();
    check_eq("perr_sticky", protocol_error, 1'b1);

    // Reset mid-transfer.
    inst_request = 1'b1; mem_address_ready = 1'b1;
    step();
    data_request = 1'b1; mem_data_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_outputs",
             {mem_request, inst_address_ready, data_address_ready,
              inst_data_ready, data_data_ready, protocol_error}, 6'b0);
    check_eq("midrst_count", dut.u_queue.count_q, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(); mem_data_ready = 1'b1;
    step();
    idle();
    step();
    check_eq("postrst_perr", protocol_error, 1'b1);
    reset_n = 1'b0;
    #2;
    model_reset();
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      inst_request      = ($urandom_range(99) < 60);
      data_request      = ($urandom_range(99) < 50);
      mem_address_ready = ($urandom_range(99) < 65);
      mem_data_ready    = (mq.size() > 0) ? ($urandom_range(99) < 50) : ($urandom_range(99) < 2);
      inst_cancel       = ($urandom_range(99) < 6);
      inst_write = $urandom_range(1); inst_size = 2'($urandom_range(3));
      inst_address = $urandom; inst_write_data = $urandom; inst_write_strobe = 4'($urandom_range(15));
      data_write = $urandom_range(1); data_size = 2'($urandom_range(3));
      data_address = $urandom; data_write_data = $urandom; data_write_strobe = 4'($urandom_range(15));
      mem_read_data = $urandom;
      step();
    end
    idle();
    check_eq("final_count", dut.u_queue.count_q, mq.size());

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_request_arbiter.md
MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 2: maximum outstanding accepted-but-unanswered downstream requests (legal 1..4).
REQ-002 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have instruction requester ports inst_request/inst_write in 1, inst_size in 2, inst_address/inst_write_data in 32, inst_write_strobe in 4; inst_address_ready/inst_data_ready out 1, inst_read_data out 32.
REQ-005 SHALL have data requester ports data_request/data_write/data_size/data_address/data_write_data/data_write_strobe (same widths, input); data_address_ready/data_data_ready out 1, data_read_data out 32.
REQ-006 SHALL have downstream ports mem_request/mem_write out 1, mem_size out 2, mem_address/mem_write_data out 32, mem_write_strobe out 4; mem_read_data in 32, mem_address_ready/mem_data_ready in 1.
REQ-007 SHALL have port inst_cancel  input  1  flush; discard responses of all instruction requests already accepted.
REQ-008 SHALL have port protocol_error  output  1  sticky flag: mem_data_ready seen with empty queue.

Function
REQ-009 SHALL grant data requester over instruction requester when both request in an unlocked cycle.
REQ-010 SHALL forward the granted requester's request, write, size, address, write_data, write_strobe to mem_* combinationally; mem_request = granted request AND queue not full.
REQ-011 SHALL lock the grant in a register when mem_request=1 and mem_address_ready=0; lock holds owner until mem_address_ready=1, then releases the same cycle.
REQ-012 SHALL drive granted requester's address_ready = mem_address_ready AND mem_request; other requester's address_ready = 0.
REQ-013 SHALL push {owner, discard=0} on mem_request AND mem_address_ready; pop head on mem_data_ready.
REQ-014 SHALL treat queue as full when count == QUEUE_DEPTH, even if a pop occurs that cycle (no bypass).
REQ-015 SHALL keep count unchanged on simultaneous push and pop; pointers wrap modulo QUEUE_DEPTH.
REQ-016 SHALL assert head owner's data_ready = mem_data_ready when head discard=0; when discard=1 pop silently with both data_ready = 0.
REQ-017 SHALL pass mem_read_data to both inst_read_data and data_read_data unregistered.
REQ-018 SHALL, on inst_cancel, set discard on every queued instruction entry, including one pushed that cycle; data entries untouched.
REQ-019 SHALL, on inst_cancel while an instruction grant is locked, keep the lock (request already visible downstream) and mark that entry discard when pushed in the cancel cycle or later until acceptance.
REQ-020 SHALL ignore mem_data_ready with empty queue (no pop, no data_ready) and set protocol_error until reset.
REQ-021 SHALL add zero cycles latency in request and response paths; throughput one accept per cycle.

Reset
REQ-022 SHALL on reset_n=0 asynchronously clear count, pointers, lock, cancel-pending, protocol_error; all ready outputs and mem_request are 0 during reset.
REQ-023 SHALL drop responses for requests outstanding at reset assertion; after release first mem_data_ready with empty queue sets protocol_error.

Structure
REQ-024 SHALL place owner enum (OWNER_INST, OWNER_DATA), queue entry struct {owner, discard} and default depth in package mem_arbiter_params.
REQ-025 SHALL implement the owner queue as sub-module response_queue (push, pop, mark-discard, full, empty, head).

Verification
REQ-026 SHALL test both request same cycle, address 0xbfc00000 inst / 0x80001000 data, mem_address_ready=1 -> data granted first, inst next cycle, responses routed data then inst.
REQ-027 SHALL test mem_address_ready held 0 for 3 cycles on inst request then data_request rises -> grant stays inst until acceptance.
REQ-028 SHALL test QUEUE_DEPTH=2, three back-to-back accepts attempted without responses -> third mem_request=0 until a pop, then accepted next cycle.
REQ-029 SHALL test two inst requests outstanding, inst_cancel pulse, then two mem_data_ready -> inst_data_ready stays 0, count returns to 0.
REQ-030 SHALL test mem_data_ready with empty queue -> protocol_error=1 held; reset_n low mid-transfer -> all outputs 0, count 0.
